// File: rtl/gru_uart_pkg.sv
// -----------------------------------------------------------------------------
// gru_uart_pkg
// Shared constants, state encodings and helpers for the GRU result UART.
//   SYNC_BYTE            - first byte of every result packet
//   PKT_BYTES            - bytes per packet (sync, 4 data bytes, checksum)
//   DEFAULT_CLKS_PER_BIT - 50 MHz / 115200 baud
//   pkt_state_t          - packet sequencer states (uart_result_tx)
//   tx_state_t           - byte sender states (uart_tx_byte)
// -----------------------------------------------------------------------------
package gru_uart_pkg;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam int         PKT_BYTES            = 6;
    localparam int         DEFAULT_CLKS_PER_BIT = 434;
    localparam logic [2:0] LAST_BYTE_IDX        = 3'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_SEND = 2'd1,
        PKT_WAIT = 2'd2,
        PKT_DONE = 2'd3
    } pkt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // XOR of the four data bytes; the sync byte does not take part.
    function automatic logic [7:0] packet_chk(input logic [31:0] word);
        return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction

    // Byte at position idx of the packet carrying word.
    function automatic logic [7:0] pkt_byte_sel(input logic [31:0] word,
                                                input logic [2:0]  idx);
        logic [7:0] sel;
        case (idx)
            3'd0:    sel = SYNC_BYTE;
            3'd1:    sel = word[31:24];
            3'd2:    sel = word[23:16];
            3'd3:    sel = word[15:8];
            3'd4:    sel = word[7:0];
            3'd5:    sel = packet_chk(word);
            default: sel = SYNC_BYTE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as 8N1: start bit 0, 8 data bits LSB first, stop bit 1,
// each bit held CLKS_PER_BIT clocks. A start request presented during the last
// stop-bit cycle is taken immediately, so consecutive bytes have no idle gap.
// Ports:
//   CLOCK_50 - clock, rising edge
//   rstn     - asynchronous active-low reset (line forced high)
//   i_start  - launch i_byte; honoured in IDLE and in the last stop-bit cycle
//   i_byte   - byte to send, sampled with i_start
//   o_done   - high during the last cycle of the stop bit
//   o_txd    - registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
    import gru_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK_50,
    input  logic       rstn,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_txd
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] baud, baud_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             txd_n;
    logic             baud_last;
    logic [2:0]       next_bit;

    assign baud_last = (baud == BAUD_LAST);
    assign next_bit  = bit_idx + 3'd1;
    assign o_done    = (state == TX_STOP) && baud_last;

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_txd   <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            o_txd   <= txd_n;
        end
    end

    // txd_n is the line value for the next cycle, so the output flop changes
    // exactly on the bit boundary.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        txd_n     = o_txd;

        case (state)
            TX_IDLE: begin
                baud_n    = '0;
                bit_idx_n = '0;
                txd_n     = 1'b1;
                if (i_start) begin
                    state_n = TX_START;
                    shreg_n = i_byte;
                    txd_n   = 1'b0;
                end
            end

            TX_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = TX_DATA;
                    txd_n   = shreg[0];
                end else begin
                    baud_n = baud + CNT_W'(1);
                end
            end

            TX_DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        state_n   = TX_STOP;
                        txd_n     = 1'b1;
                    end else begin
                        bit_idx_n = next_bit;
                        txd_n     = shreg[next_bit];
                    end
                end else begin
                    baud_n = baud + CNT_W'(1);
                end
            end

            TX_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (i_start) begin
                        state_n = TX_START;
                        shreg_n = i_byte;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = TX_IDLE;
                        txd_n   = 1'b1;
                    end
                end else begin
                    baud_n = baud + CNT_W'(1);
                end
            end

            default: begin
                state_n = TX_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_result_tx.sv
// -----------------------------------------------------------------------------
// uart_result_tx
// Sends one 32-bit GRU result as a 6-byte UART packet:
//   A5, data[31:24], data[23:16], data[15:8], data[7:0], XOR of the data bytes.
// The word is latched on acceptance; requests while busy are dropped.
// Ports:
//   CLOCK_50 - 50 MHz clock, rising edge
//   rstn     - asynchronous active-low reset; aborts a packet in flight
//   i_valid  - send request, taken only while o_ready is high
//   i_data   - result word (IEEE-754 single)
//   o_ready  - idle and able to accept (also high in the o_done cycle)
//   o_done   - one-cycle pulse in the cycle after the last stop bit
//   UART_TXD - serial line, idle high, 8N1
// -----------------------------------------------------------------------------
module uart_result_tx
    import gru_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        CLOCK_50,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic        o_done,
    output logic        UART_TXD
);

    pkt_state_t  state, state_n;
    logic [2:0]  byte_idx, byte_idx_n;
    logic [31:0] data_q, data_n;
    logic        armed;
    logic        accept;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        byte_done;

    // armed keeps o_ready low until the first edge after reset release.
    assign o_ready = armed && ((state == PKT_IDLE) || (state == PKT_DONE));
    assign o_done  = (state == PKT_DONE);
    assign accept  = o_ready && i_valid;

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            state    <= PKT_IDLE;
            byte_idx <= '0;
            data_q   <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            data_q   <= data_n;
            armed    <= 1'b1;
        end
    end

    // tx_start is raised on every transition into SEND, so the byte sender's
    // start bit coincides with the SEND cycle. For byte 0 that is the accept
    // cycle itself (start bit right after acceptance); for later bytes it is
    // the last stop-bit cycle of the previous byte (no inter-byte gap).
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        data_n     = data_q;
        tx_start   = 1'b0;
        tx_byte    = SYNC_BYTE;

        case (state)
            PKT_IDLE, PKT_DONE: begin
                state_n    = PKT_IDLE;
                byte_idx_n = '0;
                if (accept) begin
                    data_n   = i_data;
                    tx_start = 1'b1;
                    tx_byte  = SYNC_BYTE;
                    state_n  = PKT_SEND;
                end
            end

            PKT_SEND: begin
                state_n = PKT_WAIT;
            end

            PKT_WAIT: begin
                if (byte_done) begin
                    if (byte_idx < LAST_BYTE_IDX) begin
                        byte_idx_n = byte_idx + 3'd1;
                        tx_start   = 1'b1;
                        tx_byte    = pkt_byte_sel(data_q, byte_idx_n);
                        state_n    = PKT_SEND;
                    end else begin
                        state_n = PKT_DONE;
                    end
                end
            end

            default: begin
                state_n    = PKT_IDLE;
                byte_idx_n = '0;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .CLOCK_50 (CLOCK_50),
        .rstn     (rstn),
        .i_start  (tx_start),
        .i_byte   (tx_byte),
        .o_done   (byte_done),
        .o_txd    (UART_TXD)
    );

endmodule

// File: tb/tb_uart_result_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_result_tx
// Directed bench for uart_result_tx: a fast instance (4 clocks/bit) for packet
// content, timing, back-to-back and reset behaviour, and a 434 clocks/bit
// instance for the real baud rate.
// -----------------------------------------------------------------------------
module tb_uart_result_tx;

    localparam int CPB_FAST = 4;
    localparam int CPB_SLOW = 434;

    logic        CLOCK_50 = 1'b0;
    logic        rstn     = 1'b0;

    logic        i_valid  = 1'b0;
    logic [31:0] i_data   = '0;
    logic        o_ready;
    logic        o_done;
    logic        UART_TXD;

    logic        i_valid_s = 1'b0;
    logic [31:0] i_data_s  = '0;
    logic        o_ready_s;
    logic        o_done_s;
    logic        txd_s;

    int checks = 0;
    int errors = 0;

    uart_result_tx #(.CLKS_PER_BIT(CPB_FAST)) dut (
        .CLOCK_50 (CLOCK_50),
        .rstn     (rstn),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .UART_TXD (UART_TXD)
    );

    uart_result_tx #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .CLOCK_50 (CLOCK_50),
        .rstn     (rstn),
        .i_valid  (i_valid_s),
        .i_data   (i_data_s),
        .o_ready  (o_ready_s),
        .o_done   (o_done_s),
        .UART_TXD (txd_s)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? txd_s : UART_TXD;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? o_ready_s : o_ready;
    endfunction

    function automatic logic dne(input bit sel);
        return sel ? o_done_s : o_done;
    endfunction

    task automatic set_valid(input bit sel, input logic v, input logic [31:0] d);
        if (sel) begin
            i_valid_s = v;
            i_data_s  = d;
        end else begin
            i_valid = v;
            i_data  = d;
        end
    endtask

    // Decodes one packet at bit centres, measured from the first start-bit
    // cycle, and returns in the o_done cycle (60*cpb cycles later).
    task automatic rx_packet(input bit sel, input int cpb, input logic [47:0] exp_pkt,
                             input int max_wait, input bit poke, input string tag);
        logic [7:0] got [6];
        bit   frame_ok  = 1'b1;
        bit   ready_low = 1'b1;
        bit   done_seen = 1'b0;
        bit   low_open  = 1'b1;
        int   low_run   = 0;
        int   waited    = 0;
        int   pos, b, k;
        for (int i = 0; i < 6; i++) got[i] = '0;

        while (line(sel) !== 1'b0 && waited < max_wait) begin
            step();
            waited++;
        end
        check($sformatf("%s start_seen", tag), {31'd0, line(sel)}, 32'd0);
        if (line(sel) !== 1'b0) return;

        for (int t = 0; t < 60 * cpb; t++) begin
            if (low_open) begin
                if (line(sel) === 1'b0) low_run++;
                else low_open = 1'b0;
            end
            if (rdy(sel) !== 1'b0) ready_low = 1'b0;
            if (dne(sel) !== 1'b0) done_seen = 1'b1;
            if (t % cpb == cpb / 2) begin
                pos = t / cpb;
                b   = pos / 10;
                k   = pos % 10;
                if (k == 0) begin
                    if (line(sel) !== 1'b0) frame_ok = 1'b0;
                end else if (k == 9) begin
                    if (line(sel) !== 1'b1) frame_ok = 1'b0;
                end else begin
                    got[b][k-1] = line(sel);
                end
            end
            if (poke) begin
                if (t == 7 * cpb || t == 33 * cpb) set_valid(sel, 1'b1, 32'h12345678);
                else set_valid(sel, 1'b0, 32'h0);
            end
            step();
        end

        check($sformatf("%s done_at_60bits", tag), {31'd0, dne(sel)}, 32'd1);
        check($sformatf("%s ready_at_done", tag), {31'd0, rdy(sel)}, 32'd1);
        check($sformatf("%s no_early_done", tag), {31'd0, done_seen}, 32'd0);
        check($sformatf("%s ready_low_in_pkt", tag), {31'd0, ready_low}, 32'd1);
        check($sformatf("%s framing", tag), {31'd0, frame_ok}, 32'd1);
        check($sformatf("%s start_bit_width", tag), low_run, cpb);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_pkt[47-8*i -: 8]});
    endtask

    // Line must stay idle and ready for n cycles with no o_done.
    task automatic expect_idle(input int n, input string tag);
        bit quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (UART_TXD !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0) quiet = 1'b0;
            step();
        end
        check(tag, {31'd0, quiet}, 32'd1);
    endtask

    initial begin
        // Reset state
        rstn = 1'b0;
        step();
        step();
        check("rst_txd", {31'd0, UART_TXD}, 32'd1);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_txd_slow", {31'd0, txd_s}, 32'd1);
        rstn = 1'b1;
        check("ready_before_edge", {31'd0, o_ready}, 32'd0);
        step();
        check("ready_after_release", {31'd0, o_ready}, 32'd1);
        check("idle_txd", {31'd0, UART_TXD}, 32'd1);

        // 1.0f, single-cycle request
        set_valid(0, 1'b1, 32'h3F800000);
        step();
        set_valid(0, 1'b0, 32'h0);
        check("ready_drop", {31'd0, o_ready}, 32'd0);
        rx_packet(0, CPB_FAST, 48'hA5_3F_80_00_00_BF, 0, 1'b0, "pkt_1p0");
        step();
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("txd_idle_after", {31'd0, UART_TXD}, 32'd1);

        // DEADBEEF with stray requests mid-packet
        set_valid(0, 1'b1, 32'hDEADBEEF);
        step();
        set_valid(0, 1'b0, 32'h0);
        rx_packet(0, CPB_FAST, 48'hA5_DE_AD_BE_EF_22, 0, 1'b1, "pkt_dead");
        step();
        expect_idle(20, "no_extra_pkt_after_pokes");

        // Back-to-back with i_valid held high
        set_valid(0, 1'b1, 32'h00000001);
        step();
        set_valid(0, 1'b1, 32'h00000002);
        rx_packet(0, CPB_FAST, 48'hA5_00_00_00_01_01, 0, 1'b0, "pkt_b2b_1");
        check("b2b_gap_high", {31'd0, UART_TXD}, 32'd1);
        step();
        set_valid(0, 1'b0, 32'h0);
        rx_packet(0, CPB_FAST, 48'hA5_00_00_00_02_02, 0, 1'b0, "pkt_b2b_2");
        step();
        expect_idle(20, "idle_after_b2b");

        // Reset during byte 2 (0x80: data bit 0 is low)
        set_valid(0, 1'b1, 32'h3F800000);
        step();
        set_valid(0, 1'b0, 32'h0);
        for (int i = 0; i < 21 * CPB_FAST + 1; i++) step();
        check("mid_pkt_txd_low", {31'd0, UART_TXD}, 32'd0);
        #3;
        rstn = 1'b0;
        #1;
        check("abort_txd_async", {31'd0, UART_TXD}, 32'd1);
        check("abort_ready", {31'd0, o_ready}, 32'd0);
        check("abort_done", {31'd0, o_done}, 32'd0);
        step();
        step();
        check("abort_hold_txd", {31'd0, UART_TXD}, 32'd1);
        rstn = 1'b1;
        check("abort_ready_pre_edge", {31'd0, o_ready}, 32'd0);
        step();
        check("abort_ready_post_edge", {31'd0, o_ready}, 32'd1);
        expect_idle(25 * CPB_FAST, "no_resume_after_abort");
        set_valid(0, 1'b1, 32'hDEADBEEF);
        step();
        set_valid(0, 1'b0, 32'h0);
        rx_packet(0, CPB_FAST, 48'hA5_DE_AD_BE_EF_22, 0, 1'b0, "pkt_after_abort");
        step();

        // Real baud rate, pi
        check("slow_ready", {31'd0, o_ready_s}, 32'd1);
        set_valid(1, 1'b1, 32'h40490FDB);
        step();
        set_valid(1, 1'b0, 32'h0);
        rx_packet(1, CPB_SLOW, 48'hA5_40_49_0F_DB_DD, 0, 1'b0, "pkt_slow_pi");
        step();
        check("slow_done_one_cycle", {31'd0, o_done_s}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning CLOCK_50 cycles per UART bit (115200 baud); SHALL be >= 2.
REQ-002 CLOCK_50  input  1  system clock, 50 MHz; all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request to send i_data; sampled only while o_ready=1.
REQ-005 i_data  input  32  result word, IEEE-754 single (GRU prediction).
REQ-006 o_ready  output  1  high when idle and able to accept a request.
REQ-007 o_done  output  1  one-cycle pulse at end of packet.
REQ-008 UART_TXD  output  1  serial line, idle high, 8N1.

Function
REQ-009 Accept SHALL occur on a cycle where i_valid=1 and o_ready=1: latch i_data, drop o_ready on the next cycle.
REQ-010 i_valid while o_ready=0 SHALL be ignored (no queueing, no effect on the frame in progress).
REQ-011 Packet SHALL be 6 bytes in order: 0xA5, i_data[31:24], [23:16], [15:8], [7:0], CHK.
REQ-012 CHK SHALL be the bitwise XOR of the four data bytes (sync byte excluded).
REQ-013 Each byte SHALL be framed as start bit 0, 8 data bits LSB first, stop bit 1; every bit held exactly CLKS_PER_BIT cycles.
REQ-014 The start bit of byte 0 SHALL begin on the cycle after acceptance.
REQ-015 No idle gap between bytes: the next start bit SHALL follow the previous stop bit immediately.
REQ-016 Packet duration SHALL be exactly 60*CLKS_PER_BIT cycles, counted from the first start-bit cycle.
REQ-017 o_done SHALL pulse for one cycle on the cycle after the last stop-bit cycle; o_ready SHALL go high on that same cycle.
REQ-018 A request accepted on the o_done cycle SHALL start its start bit on the next cycle (back-to-back packets, 1-cycle TXD-high gap).
REQ-019 Top FSM states: IDLE (o_ready=1), SEND (issue byte index 0..5 to byte sender), WAIT (await byte done), DONE (pulse o_done, return to IDLE).
REQ-020 Transitions: IDLE->SEND on accept; SEND->WAIT; WAIT->SEND on byte done if index<5, else ->DONE; DONE->IDLE.
REQ-021 Byte sender states: IDLE, START, DATA (bit index 0..7), STOP; baud counter counts 0..CLKS_PER_BIT-1 and wraps.
REQ-022 UART_TXD SHALL be registered (glitch-free); no combinational path from i_* to UART_TXD.
REQ-023 Byte index (3 bits) and bit index (3 bits) SHALL never exceed 5 and 7 respectively.

Reset
REQ-024 While rstn=0: UART_TXD=1, o_ready=0, o_done=0, both FSMs IDLE, all counters and latched data 0.
REQ-025 o_ready SHALL go high on the first clock edge after rstn deasserts.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately (TXD high asynchronously); no partial resumption after release.

Structure
REQ-027 Shared package gru_uart_pkg SHALL hold: SYNC_BYTE=8'hA5, PKT_BYTES=6, default CLKS_PER_BIT=434, top FSM state encoding.
REQ-028 One sub-module uart_tx_byte (CLKS_PER_BIT param; i_start, i_byte[7:0], o_done, o_txd) SHALL implement REQ-013/REQ-021; uart_result_tx owns packet sequencing and checksum.
REQ-029 Intended integration: GRU_top drives i_valid from model_done and i_data from final_prediction, replacing the constant-high UART_TXD.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 i_data=32'h3F800000, one-cycle i_valid -> bytes A5 3F 80 00 00 BF decoded at bit centres; o_done exactly 240 cycles after the first start bit begins.
REQ-031 i_data=32'hDEADBEEF -> bytes A5 DE AD BE EF 22; o_ready low for the whole packet.
REQ-032 i_valid held high continuously with 0x00000001 then 0x00000002 -> two packets (CHK 01, then 02), exactly one TXD-high cycle between them; i_valid pulses during a packet produce no extra packet.
REQ-033 rstn pulsed low during byte 2 of a packet -> TXD=1 immediately, no o_done, o_ready=1 one edge after release, next request sends a complete correct packet.
REQ-034 CLKS_PER_BIT=434, i_data=32'h40490FDB -> each bit width 434 cycles (8.68 us), CHK=0x40^0x49^0x0F^0xDB=0xDD.
